// File: rtl/acf_pkg.sv
// rtl/acf_pkg.sv - shared types and constants for the ACF burst transmitter
package acf_pkg;

  typedef enum logic [3:0] {
    IDLE, LOAD_HDR, SEND, ACK, DRAIN, FETCH, WAIT_RD, NEXT_BYTE, LOAD_FTR, DONE
  } tx_state_t;

  // Which kind of byte is in flight, so DRAIN knows where to go next
  typedef enum logic [1:0] {SRC_HDR, SRC_DATA, SRC_FTR} src_t;

  localparam logic [7:0] ACF_HEADER = 8'hA5;
  localparam logic [7:0] ACF_FOOTER = 8'h5A;

  function automatic int bytes_per_word(input int word_size, input int data_size);
    return word_size / data_size;
  endfunction

endpackage

// File: rtl/acf_burst_tx_if.sv
// rtl/acf_burst_tx_if.sv - result FIFO read port and UART TX handshake bundle
interface acf_burst_tx_if #(
  parameter int WORD_SIZE = 32,
  parameter int DATA_SIZE = 8
);
  logic [WORD_SIZE-1:0] fifo_dout;
  logic                 fifo_empty;
  logic                 fifo_rd_en;
  logic [DATA_SIZE-1:0] tx_data;
  logic                 tx_start;
  logic                 tx_busy;

  modport master (
    input  fifo_dout, fifo_empty, tx_busy,
    output fifo_rd_en, tx_data, tx_start
  );

  modport slave (
    output fifo_dout, fifo_empty, tx_busy,
    input  fifo_rd_en, tx_data, tx_start
  );
endinterface

// File: rtl/acf_word_serializer.sv
// rtl/acf_word_serializer.sv - word shift register emitting bytes MSB first
module acf_word_serializer
  import acf_pkg::*;
#(
  parameter int WORD_SIZE = 32,
  parameter int DATA_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 shift,
  input  logic [WORD_SIZE-1:0] word,
  output logic [DATA_SIZE-1:0] top_byte,
  output logic                 last_byte
);
  localparam int BPW = bytes_per_word(WORD_SIZE, DATA_SIZE);
  localparam int BCW = $clog2(BPW + 1);

  logic [WORD_SIZE-1:0] shreg;
  logic [BCW-1:0]       byte_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg    <= '0;
      byte_cnt <= '0;
    end else if (load) begin
      shreg    <= word;
      byte_cnt <= '0;
    end else if (shift) begin
      shreg    <= shreg << DATA_SIZE;
      byte_cnt <= byte_cnt + BCW'(1);
    end
  end

  assign top_byte  = shreg[WORD_SIZE-1 -: DATA_SIZE];
  // True once every byte of the loaded word has been handed out
  assign last_byte = (byte_cnt == BCW'(BPW));

endmodule

// File: rtl/acf_burst_tx.sv
// rtl/acf_burst_tx.sv - frames one burst of FIFO words as header, MSB-first bytes, footer over UART
module acf_burst_tx
  import acf_pkg::*;
#(
  parameter int                   WORD_SIZE = 32,
  parameter int                   DATA_SIZE = 8,
  parameter int                   BURST_LEN = 16,
  parameter logic [DATA_SIZE-1:0] HEADER    = ACF_HEADER,
  parameter logic [DATA_SIZE-1:0] FOOTER    = ACF_FOOTER
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           initTx,
  acf_burst_tx_if.master bus,
  output logic           busy,
  output logic           burstDone,
  output logic           underrun
);
  localparam int WCW = $clog2(BURST_LEN + 1);

  tx_state_t            state, state_nxt;
  src_t                 src, src_nxt;
  logic [WCW-1:0]       word_cnt, word_cnt_nxt;
  logic                 rd_wait, rd_wait_nxt;
  logic                 rd_en, rd_en_nxt;
  logic                 tx_start, tx_start_nxt;
  logic [DATA_SIZE-1:0] tx_data, tx_data_nxt;
  logic                 busy_nxt, done_nxt, underrun_nxt;
  logic                 ser_load, ser_shift, last_byte;
  logic [WORD_SIZE-1:0] ser_word;
  logic [DATA_SIZE-1:0] top_byte;

  acf_word_serializer #(.WORD_SIZE(WORD_SIZE), .DATA_SIZE(DATA_SIZE)) u_ser (
    .clk(clk), .rst(rst), .load(ser_load), .shift(ser_shift),
    .word(ser_word), .top_byte(top_byte), .last_byte(last_byte)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      src       <= SRC_HDR;
      word_cnt  <= '0;
      rd_wait   <= 1'b0;
      rd_en     <= 1'b0;
      tx_start  <= 1'b0;
      tx_data   <= '0;
      busy      <= 1'b0;
      burstDone <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      state     <= state_nxt;
      src       <= src_nxt;
      word_cnt  <= word_cnt_nxt;
      rd_wait   <= rd_wait_nxt;
      rd_en     <= rd_en_nxt;
      tx_start  <= tx_start_nxt;
      tx_data   <= tx_data_nxt;
      busy      <= busy_nxt;
      burstDone <= done_nxt;
      underrun  <= underrun_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    src_nxt      = src;
    word_cnt_nxt = word_cnt;
    rd_wait_nxt  = 1'b0;
    rd_en_nxt    = 1'b0;
    tx_start_nxt = 1'b0;
    tx_data_nxt  = tx_data;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    underrun_nxt = underrun;
    ser_load     = 1'b0;
    ser_shift    = 1'b0;
    ser_word     = '0;
    unique case (state)
      IDLE: if (initTx) begin
        state_nxt    = LOAD_HDR;
        busy_nxt     = 1'b1;
        underrun_nxt = 1'b0;
        word_cnt_nxt = '0;
      end
      LOAD_HDR: begin
        tx_data_nxt = HEADER;
        src_nxt     = SRC_HDR;
        state_nxt   = SEND;
      end
      SEND: if (!bus.tx_busy) begin
        tx_start_nxt = 1'b1;
        state_nxt    = ACK;
      end
      ACK: if (bus.tx_busy) state_nxt = DRAIN;
      DRAIN: if (!bus.tx_busy) begin
        case (src)
          SRC_HDR:  state_nxt = FETCH;
          SRC_DATA: begin
            if (!last_byte)                   state_nxt = NEXT_BYTE;
            else if (word_cnt != WCW'(BURST_LEN)) state_nxt = FETCH;
            else                              state_nxt = LOAD_FTR;
          end
          default:  state_nxt = DONE;
        endcase
      end
      FETCH: begin
        word_cnt_nxt = word_cnt + WCW'(1);
        src_nxt      = SRC_DATA;
        if (!bus.fifo_empty) begin
          rd_en_nxt = 1'b1;
          state_nxt = WAIT_RD;
        end else begin
          // Missing words go out as zeros so the burst length never changes
          ser_load     = 1'b1;
          underrun_nxt = 1'b1;
          state_nxt    = NEXT_BYTE;
        end
      end
      // The registered strobe reaches the FIFO one cycle late, so data lands a cycle after that
      WAIT_RD: begin
        if (rd_wait) begin
          ser_word  = bus.fifo_dout;
          ser_load  = 1'b1;
          state_nxt = NEXT_BYTE;
        end else begin
          rd_wait_nxt = 1'b1;
        end
      end
      NEXT_BYTE: begin
        tx_data_nxt = top_byte;
        ser_shift   = 1'b1;
        state_nxt   = SEND;
      end
      LOAD_FTR: begin
        tx_data_nxt = FOOTER;
        src_nxt     = SRC_FTR;
        state_nxt   = SEND;
      end
      DONE: begin
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.tx_start   = tx_start;
  assign bus.tx_data    = tx_data;

endmodule

// File: tb/tb_acf_burst_tx.sv
// tb/tb_acf_burst_tx.sv - self-checking bench for acf_burst_tx with FIFO and UART models
module tb_acf_burst_tx;
  localparam int WS = 32, DS = 8, BL = 2, BPW = 4, NB = 2 + BL * BPW;

  logic clk = 1'b0, rst = 1'b1, initTx = 1'b0;
  logic busy, burstDone, underrun;

  acf_burst_tx_if #(.WORD_SIZE(WS), .DATA_SIZE(DS)) bus ();

  acf_burst_tx #(.WORD_SIZE(WS), .DATA_SIZE(DS), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst), .initTx(initTx), .bus(bus),
    .busy(busy), .burstDone(burstDone), .underrun(underrun)
  );

  always #5 clk = ~clk;

  // FIFO model: data appears the cycle after the FIFO samples rd_en
  logic [WS-1:0] mem [0:63];
  int wr_ptr = 0, rd_ptr = 0, rd_empty = 0, n_rd = 0;
  assign bus.fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge clk) begin
    if (bus.fifo_rd_en === 1'b1) begin
      n_rd <= n_rd + 1;
      if (wr_ptr == rd_ptr) rd_empty <= rd_empty + 1;
      else begin
        bus.fifo_dout <= mem[rd_ptr[5:0]];
        rd_ptr        <= rd_ptr + 1;
      end
    end
  end

  // UART model: busy rises the cycle after tx_start, lasts busy_cycles
  logic [7:0] cap [0:1023];
  int n_start = 0, overlap = 0, ucnt = 0, busy_cycles = 10, n_done = 0;
  assign bus.tx_busy = (ucnt != 0);
  always @(posedge clk) begin
    if (bus.tx_start === 1'b1) begin
      cap[n_start[9:0]] <= bus.tx_data;
      n_start <= n_start + 1;
      if (ucnt != 0) overlap <= overlap + 1;
      ucnt <= busy_cycles;
    end else if (ucnt != 0) begin
      ucnt <= ucnt - 1;
    end
  end
  always @(posedge clk) if (burstDone === 1'b1) n_done <= n_done + 1;

  int errors = 0, checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int            n_avail;
    logic [WS-1:0] w0;
    logic [WS-1:0] w1;
    int            mode;          // 0 plain, 1 re-pulse initTx, 2 UART stuck busy
    int            exp_reads;
    logic          exp_underrun;
  } vec_t;
  vec_t vecs [0:9];

  logic [7:0] exp_b [0:NB-1];
  int exp_n;

  // Reference: header, then each word (zero when the FIFO ran dry) MSB byte first, then footer
  task automatic build_model(input vec_t v);
    logic [WS-1:0] word;
    exp_n = 0;
    exp_b[exp_n] = 8'hA5; exp_n++;
    for (int wi = 0; wi < BL; wi++) begin
      word = (wi >= v.n_avail) ? '0 : ((wi == 0) ? v.w0 : v.w1);
      for (int b = 0; b < BPW; b++) begin
        exp_b[exp_n] = 8'(word >> (DS * (BPW - 1 - b)));
        exp_n++;
      end
    end
    exp_b[exp_n] = 8'h5A; exp_n++;
  endtask

  task automatic push_words(input vec_t v);
    wr_ptr = rd_ptr;
    for (int i = 0; i < v.n_avail; i++) begin
      mem[wr_ptr[5:0]] = (i == 0) ? v.w0 : v.w1;
      wr_ptr++;
    end
  endtask

  task automatic run_burst(input vec_t v, input int row);
    int sb, rb, db, c1, idx;
    bit got, pulsed;
    push_words(v);
    build_model(v);
    sb = n_start; rb = n_rd; db = n_done;
    got = 0; pulsed = 0; c1 = -1;
    if (v.mode == 2) busy_cycles = 500;
    @(negedge clk); initTx = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      initTx = 1'b0;
      if (c == 0) begin
        check($sformatf("r%0d busy after accept", row), busy, 1);
        check($sformatf("r%0d underrun cleared", row), underrun, 0);
        check($sformatf("r%0d tx_start early", row), bus.tx_start, 0);
      end
      if (c == 2) begin
        check($sformatf("r%0d header latency", row), bus.tx_start, 1);
        check($sformatf("r%0d header data", row), bus.tx_data, 8'hA5);
      end
      if (v.mode == 1 && !pulsed && (n_start - sb) == 4) begin
        initTx = 1'b1;
        pulsed = 1;
      end
      if (v.mode == 2 && c1 < 0 && (n_start - sb) == 1) begin
        busy_cycles = 10;
        c1 = c;
      end
      if (v.mode == 2 && c1 >= 0 && c == c1 + 400)
        check($sformatf("r%0d no start while stuck", row), n_start - sb, 1);
      if (burstDone === 1'b1) begin
        got = 1;
        break;
      end
    end
    busy_cycles = 10;
    check($sformatf("r%0d burstDone seen", row), got, 1);
    check($sformatf("r%0d byte count", row), n_start - sb, exp_n);
    for (int i = 0; i < exp_n; i++) begin
      idx = sb + i;
      check($sformatf("r%0d byte %0d", row, i), cap[idx[9:0]], exp_b[i]);
    end
    check($sformatf("r%0d fifo reads", row), n_rd - rb, v.exp_reads);
    check($sformatf("r%0d underrun", row), underrun, v.exp_underrun);
    check($sformatf("r%0d busy at done", row), busy, 0);
    @(posedge clk); #1;
    check($sformatf("r%0d done pulses", row), n_done - db, 1);
  endtask

  initial begin
    int n, sb;
    vecs[0] = '{2, 32'h11223344, 32'hAABBCCDD, 0, 2, 1'b0};
    vecs[1] = '{1, 32'h01020304, 32'h00000000, 0, 1, 1'b1};
    vecs[2] = '{1, 32'h0A0B0C0D, 32'h00000000, 1, 1, 1'b1};
    vecs[3] = '{2, 32'hDEADBEEF, 32'h01234567, 0, 2, 1'b0};
    vecs[4] = '{2, 32'hCAFEF00D, 32'h80000001, 2, 2, 1'b0};
    vecs[5] = '{0, 32'h00000000, 32'h00000000, 0, 0, 1'b1};
    for (int i = 6; i < 10; i++) begin
      n = int'($urandom_range(2, 0));
      vecs[i] = '{n, $urandom, $urandom, 0, (n < BL) ? n : BL, (n < BL)};
    end

    repeat (3) @(negedge clk);
    check("reset fifo_rd_en", bus.fifo_rd_en, 0);
    check("reset tx_data", bus.tx_data, 0);
    check("reset tx_start", bus.tx_start, 0);
    check("reset busy", busy, 0);
    check("reset burstDone", burstDone, 0);
    check("reset underrun", underrun, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_burst(vecs[i], i);

    // Reset in the middle of a burst
    push_words(vecs[0]);
    sb = n_start;
    @(negedge clk); initTx = 1'b1;
    @(negedge clk); initTx = 1'b0;
    for (int c = 0; c < 500 && (n_start - sb) < 3; c++) @(negedge clk);
    check("reached third byte", n_start - sb, 3);
    rst = 1'b1;
    @(negedge clk);
    check("rst busy", busy, 0);
    check("rst tx_start", bus.tx_start, 0);
    check("rst fifo_rd_en", bus.fifo_rd_en, 0);
    rst = 1'b0;
    sb = n_start;
    repeat (60) @(negedge clk);
    check("no bytes after rst", n_start - sb, 0);
    run_burst(vecs[3], 10);

    check("tx_start while busy", overlap, 0);
    check("read while empty", rd_empty, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
